// File: rtl/alu_share_arbiter_pkg.sv
// Shared encodings for the execute-stage shared ALU: function selects,
// condition-code bit positions, CC reset value and arbiter FSM states.
package alu_share_arbiter_pkg;

    localparam logic [1:0] FN_ADD = 2'd0;
    localparam logic [1:0] FN_SUB = 2'd1;
    localparam logic [1:0] FN_AND = 2'd2;
    localparam logic [1:0] FN_XOR = 2'd3;

    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;

    // ZF set out of reset so a branch before any flag-setting op sees "equal"
    localparam logic [2:0] CC_RESET = 3'b001;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

endpackage

// File: rtl/alu_share_if.sv
// Two-requester valid/ready request bus plus the registered response and CC view.
// master = requester side (bench / execute stage), slave = the shared ALU arbiter.
interface alu_share_if #(
    parameter int WIDTH = 64,
    parameter int FN_W  = 2
);
    logic             req0_valid;
    logic             req0_ready;
    logic [FN_W-1:0]  req0_fn;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_set_cc;

    logic             req1_valid;
    logic             req1_ready;
    logic [FN_W-1:0]  req1_fn;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_set_cc;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       cc;

    modport master (
        output req0_valid, req0_fn, req0_a, req0_b, req0_set_cc,
        output req1_valid, req1_fn, req1_a, req1_b, req1_set_cc,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, cc
    );

    modport slave (
        input  req0_valid, req0_fn, req0_a, req0_b, req0_set_cc,
        input  req1_valid, req1_fn, req1_a, req1_b, req1_set_cc,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, cc
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational add/sub/and/xor ALU with {OF,SF,ZF} flags; sub computes b-a.
// Latency: none (pure combinational).
// Backpressure: none; result is valid whenever inputs are.
module alu_64bit
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FN_W  = 2
) (
    input  logic [FN_W-1:0]  fn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flags
);
    localparam int MSB = WIDTH - 1;

    logic of;

    always_comb begin
        out = '0;
        of  = 1'b0;
        case (fn)
            FN_ADD: begin
                out = a + b;
                of  = (a[MSB] == b[MSB]) && (out[MSB] != a[MSB]);
            end
            FN_SUB: begin
                // Y86 order: b is the destination, a is subtracted from it
                out = b - a;
                of  = (a[MSB] != b[MSB]) && (out[MSB] != b[MSB]);
            end
            FN_AND: out = a & b;
            default: out = a ^ b;
        endcase

        flags        = '0;
        flags[CC_OF] = of;
        flags[CC_SF] = out[MSB];
        flags[CC_ZF] = (out == '0);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters; owns the {OF,SF,ZF} register.
// Latency: accept on edge N, registered rsp_valid/rsp_data after edge N+1.
// Backpressure: ready only in IDLE for the granted requester; one op in flight.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FN_W  = 2
) (
    input  logic       clk,
    input  logic       rst,
    alu_share_if.slave bus
);
    typedef struct packed {
        logic [FN_W-1:0]  fn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             set_cc;
        logic             id;
    } op_t;

    logic [0:0]       state;
    logic             last_grant;
    logic             grant_vld;
    logic             grant_id;
    op_t              op_sel;
    op_t              op_q;

    logic [WIDTH-1:0] alu_out;
    logic [2:0]       alu_flags;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [2:0]       cc_q;

    // Ties go to whoever did not win last time; a lone requester always wins.
    always_comb begin
        grant_vld = (state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
        grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;

        op_sel.fn     = grant_id ? bus.req1_fn     : bus.req0_fn;
        op_sel.a      = grant_id ? bus.req1_a      : bus.req0_a;
        op_sel.b      = grant_id ? bus.req1_b      : bus.req0_b;
        op_sel.set_cc = grant_id ? bus.req1_set_cc : bus.req0_set_cc;
        op_sel.id     = grant_id;
    end

    assign bus.req0_ready = grant_vld && !grant_id;
    assign bus.req1_ready = grant_vld &&  grant_id;

    alu_64bit #(
        .WIDTH (WIDTH),
        .FN_W  (FN_W)
    ) u_alu (
        .fn    (op_q.fn),
        .a     (op_q.a),
        .b     (op_q.b),
        .out   (alu_out),
        .flags (alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            cc_q        <= CC_RESET;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        op_q       <= op_sel;
                        last_grant <= grant_id;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= alu_out;
                    rsp_id_q    <= op_q.id;
                    rsp_valid_q <= 1'b1;
                    if (op_q.set_cc) begin
                        cc_q <= alu_flags;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.cc        = cc_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_share_if #(.WIDTH(W), .FN_W(2)) bus ();

    alu_share_arbiter #(.WIDTH(W), .FN_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit        m_busy;
    bit        m_last;
    bit [1:0]  m_fn;
    bit [63:0] m_a, m_b;
    bit        m_set, m_id;
    bit        m_rv, m_rid;
    bit [63:0] m_rd;
    bit [2:0]  m_cc;

    // Returns {OF,SF,ZF,result}; overflow taken from a 65-bit signed sum.
    function automatic bit [66:0] ref_alu(input bit [1:0] fn, input bit [63:0] a, input bit [63:0] b);
        bit signed [64:0] sa, sb, full;
        bit [63:0] r;
        bit of;
        sa = {a[63], a};
        sb = {b[63], b};
        of = 1'b0;
        r  = '0;
        case (fn)
            2'd0: begin full = sa + sb; r = full[63:0]; of = (full[64] != full[63]); end
            2'd1: begin full = sb - sa; r = full[63:0]; of = (full[64] != full[63]); end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        return {of, r[63], (r == 64'd0), r};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_rv = 0; m_rid = 0; m_rd = '0; m_cc = 3'b001;
    endtask

    function automatic bit model_winner();
        if (bus.req0_valid && bus.req1_valid) return !m_last;
        return bus.req1_valid;
    endfunction

    task automatic model_step();
        bit [66:0] res;
        bit w;
        m_rv = 0;
        if (m_busy) begin
            res = ref_alu(m_fn, m_a, m_b);
            m_rd = res[63:0];
            m_rid = m_id;
            m_rv = 1;
            if (m_set) m_cc = res[66:64];
            m_busy = 0;
        end else if (bus.req0_valid || bus.req1_valid) begin
            w = model_winner();
            m_fn  = w ? bus.req1_fn : bus.req0_fn;
            m_a   = w ? bus.req1_a : bus.req0_a;
            m_b   = w ? bus.req1_b : bus.req0_b;
            m_set = w ? bus.req1_set_cc : bus.req0_set_cc;
            m_id  = w;
            m_last = w;
            m_busy = 1;
        end
    endtask

    // Compare process: outputs checked mid-cycle, model advanced on each edge.
    initial begin
        bit any, w;
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            any = bus.req0_valid || bus.req1_valid;
            w = model_winner();
            chk("m_ready0", bus.req0_ready, !m_busy && any && !w);
            chk("m_ready1", bus.req1_ready, !m_busy && any && w);
            chk("m_rsp_valid", bus.rsp_valid, m_rv);
            chk("m_rsp_id", bus.rsp_id, m_rid);
            chk("m_rsp_data", bus.rsp_data, m_rd);
            chk("m_cc", bus.cc, m_cc);
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit id, input bit vld, input bit [1:0] fn,
                         input bit [63:0] a, input bit [63:0] b, input bit set);
        if (id) begin
            bus.req1_valid = vld; bus.req1_fn = fn; bus.req1_a = a; bus.req1_b = b; bus.req1_set_cc = set;
        end else begin
            bus.req0_valid = vld; bus.req0_fn = fn; bus.req0_a = a; bus.req0_b = b; bus.req0_set_cc = set;
        end
    endtask

    // Present a request and hold it until accepted; returns just after the accept edge.
    task automatic issue(input bit id, input bit [1:0] fn, input bit [63:0] a,
                         input bit [63:0] b, input bit set);
        bit acc;
        acc = 0;
        drive(id, 1'b1, fn, a, b, set);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = id ? bus.req1_ready : bus.req0_ready;
            step();
        end
        if (id) bus.req1_valid = 1'b0;
        else bus.req0_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL issue_timeout: requester %0d never got ready, want ready within 20 cycles", id);
        end
    endtask

    task automatic expect_rsp(input string tag, input bit id, input bit [63:0] data, input bit [2:0] cc);
        step();
        @(negedge clk);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
        chk({tag, "_rsp_id"}, bus.rsp_id, id);
        chk({tag, "_rsp_data"}, bus.rsp_data, data);
        chk({tag, "_cc"}, bus.cc, cc);
        step();
        @(negedge clk);
        chk({tag, "_rsp_drop"}, bus.rsp_valid, 1'b0);
        step();
    endtask

    function automatic bit [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive_random(input bit id);
        drive(id, 1'b1, 2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit a0, a1;
        int half;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;

        // Reset state with no requests
        repeat (2) @(negedge clk);
        chk("rst_cc", bus.cc, 3'b001);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_ready0", bus.req0_ready, 1'b0);
        chk("rst_ready1", bus.req1_ready, 1'b0);

        // Lone requester 1 gets ready straight after release
        step();
        rst = 1'b0;
        drive(1, 1'b1, FN_ADD, 64'd3, 64'd4, 1'b0);
        @(negedge clk);
        chk("t1_ready1", bus.req1_ready, 1'b1);
        chk("t1_ready0", bus.req0_ready, 1'b0);
        step();
        bus.req1_valid = 1'b0;
        expect_rsp("t1", 1'b1, 64'd7, 3'b001);

        // Signed overflow on add
        issue(0, FN_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        expect_rsp("t2", 1'b0, 64'h8000_0000_0000_0000, 3'b110);

        // Zero result without CC write leaves flags untouched
        issue(1, FN_SUB, 64'd5, 64'd5, 1'b0);
        expect_rsp("t4", 1'b1, 64'd0, 3'b110);

        // Sub overflow (b-a), then xor to zero
        issue(0, FN_SUB, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
        expect_rsp("t5a", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100);
        issue(0, FN_XOR, 64'hDEAD, 64'hDEAD, 1'b1);
        expect_rsp("t5b", 1'b0, 64'd0, 3'b001);

        // Reset while an op is in EXEC: op dropped, cc back to reset value
        issue(1, FN_ADD, 64'd9, 64'd9, 1'b0);
        expect_rsp("t6pre", 1'b1, 64'd18, 3'b001);
        issue(0, FN_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rsp_valid_a", bus.rsp_valid, 1'b0);
        chk("t6_cc_a", bus.cc, 3'b001);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid_b", bus.rsp_valid, 1'b0);
        chk("t6_cc_b", bus.cc, 3'b001);
        step();

        // Both held valid: first tie goes to 0, then strict alternation
        drive_random(0);
        drive_random(1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            half = k / 2;
            if (k % 2 == 0) begin
                chk("t3_ready0", bus.req0_ready, (half % 2) == 0);
                chk("t3_ready1", bus.req1_ready, (half % 2) == 1);
                if (k >= 2) begin
                    chk("t3_rsp_valid", bus.rsp_valid, 1'b1);
                    chk("t3_rsp_id", bus.rsp_id, (half - 1) % 2);
                end
            end else begin
                chk("t3_idle_ready0", bus.req0_ready, 1'b0);
                chk("t3_idle_ready1", bus.req1_ready, 1'b0);
                chk("t3_idle_rsp", bus.rsp_valid, 1'b0);
            end
            a0 = bus.req0_ready;
            a1 = bus.req1_ready;
            step();
            if (a0) drive_random(0);
            if (a1) drive_random(1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Random traffic with withdrawals and occasional resets
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            step();
            rst = ($urandom_range(0, 99) == 0);
            if (a0 || !bus.req0_valid) begin
                if ($urandom_range(0, 1) == 1) drive_random(0);
                else bus.req0_valid = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (a1 || !bus.req1_valid) begin
                if ($urandom_range(0, 1) == 1) drive_random(1);
                else bus.req1_valid = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req1_valid = 1'b0;
            end
        end

        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 64-bit ALU (add/sub/and/xor) between two requesters in the execute stage, e.g. the OPq/address path and the stack-pointer update path.
- Round-robin arbitration, one operation in flight, registered result.
- Owns the architectural condition-code register {OF,SF,ZF}. It is updated only when the granted request asks for it.

Parameters:
- WIDTH, 64, operand/result width. Flag rules below assume MSB = WIDTH-1.
- FN_W, 2, function-select width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 accepted on this edge when valid&ready.
- req0_fn  in  FN_W  00 add, 01 sub, 10 and, 11 xor.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_set_cc  in  1  write CC from this operation.
- req1_valid, req1_ready, req1_fn, req1_a, req1_b, req1_set_cc: same as requester 0.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  1  index of the requester that owns rsp_data.
- rsp_data  out  WIDTH  registered result.
- cc  out  3  condition codes {OF,SF,ZF}: bit2 OF, bit1 SF, bit0 ZF.

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE, last_grant=1 (requester 0 wins first tie);
  - rsp_valid=0, rsp_id=0, rsp_data=0;
  - cc=3'b001 (ZF=1).
- FSM states: IDLE, EXEC.
- Grant (combinational, IDLE only):
  - only one valid → grant it;
  - both valid → grant !last_grant;
  - reqN_ready = (state==IDLE) && grant==N.
  - Ready may depend on valid. Valid must not depend on ready. Requesters hold valid and operands stable until accepted.
- IDLE → EXEC on the accept edge:
  - latch fn, a, b, set_cc and id;
  - last_grant <= id.
- EXEC → IDLE on the next edge:
  - rsp_data <= ALU result; rsp_id <= latched id; rsp_valid <= 1;
  - if latched set_cc, cc <= flags, else cc holds.
- rsp_valid is high for exactly one cycle (the cycle after the EXEC edge), then returns to 0 unless another EXEC completes.
- In that response cycle state is IDLE, so a new accept can occur. Latency: accept edge N, response visible after edge N+1. Max throughput: 1 op per 2 cycles.
- No ready is asserted in EXEC. A request arriving during EXEC waits.
- Arithmetic is modulo 2^WIDTH, two's complement:
  - add: a+b;
  - sub: b-a (Y86 operand order);
  - and: a&b;
  - xor: a^b.
- Flags:
  - ZF = (result==0);
  - SF = result[MSB];
  - OF for add = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]);
  - OF for sub = (a[MSB]!=b[MSB]) && (result[MSB]!=b[MSB]);
  - OF for and/xor = 0.
- Reset mid-EXEC: operation dropped, no rsp_valid, cc returns to 001.
- Simultaneous rst and accept: reset wins.
- A requester that deasserts valid before being granted loses nothing. Arbitration re-evaluates every IDLE cycle.

Decomposition:
- Shared package holds:
  - ALU function encodings (FN_ADD=0, FN_SUB=1, FN_AND=2, FN_XOR=3);
  - CC bit indices (CC_ZF=0, CC_SF=1, CC_OF=2);
  - CC reset value 3'b001;
  - state encoding (IDLE, EXEC).
- One combinational sub-module, alu_64bit (fn, a, b → out, flags[2:0]), reusable by the sequential CPU.
- Arbitration, FSM and registers stay in this module.

Test Plan:
1. Reset with no valids → cc=001, rsp_valid=0, req0_ready=req1_ready=0. After release with req1_valid only → req1_ready=1.
2. Overflowing add: req0 add a=64'h7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1, accepted at edge N → after edge N+1: rsp_valid=1, rsp_id=0, rsp_data=64'h8000_0000_0000_0000, cc=110. rsp_valid=0 one cycle later.
3. Both requesters held valid for 8 cycles → grants 0,1,0,1 (accepts every 2nd cycle), rsp_id alternates 0,1,0,1.
4. Sub without CC update: req1 sub a=5, b=5, set_cc=0 after cc=110 → rsp_data=0, cc stays 110.
5. Sub overflow: req0 sub a=1, b=64'h8000_0000_0000_0000, set_cc=1 → rsp_data=64'h7FFF_FFFF_FFFF_FFFF, cc=100. Then xor a=b=64'hDEAD, set_cc=1 → rsp_data=0, cc=001.
6. Reset mid-operation: rst pulse during EXEC of req0 add → no rsp_valid pulse, state IDLE, cc=001. Next grant goes to req0 on a tie.
